// File: rtl/time_pkg.sv
// Shared constants and BCD helper functions for the time counter.
// Packed multi-field values hold up to MAX_FIELDS 8-bit fields, field 0 in the low byte.
package time_pkg;

    localparam int BCD_W           = 4;
    localparam int FIELD_W         = 8;
    localparam logic [7:0] SEC_MAX = 8'h59;
    localparam int MAX_FIELDS      = 8;

    // True when both digits are decimal and the field does not exceed max_value.
    function automatic logic bcd_field_valid(input logic [FIELD_W-1:0] value,
                                             input logic [FIELD_W-1:0] max_value);
        return (value[BCD_W-1:0] <= 4'd9) && (value[FIELD_W-1:BCD_W] <= 4'd9) &&
               (value <= max_value);
    endfunction

    // All-max pattern: top field at top, every lower field at SEC_MAX, unused bytes zero.
    function automatic logic [FIELD_W*MAX_FIELDS-1:0] bcd_all_max(input int fields,
                                                                  input logic [FIELD_W-1:0] top);
        logic [FIELD_W*MAX_FIELDS-1:0] result;
        result = {(FIELD_W*MAX_FIELDS){1'b0}};
        for (int i = 0; i < MAX_FIELDS; i++) begin
            if (i < fields - 1) begin
                result[FIELD_W*i +: FIELD_W] = SEC_MAX;
            end else if (i == fields - 1) begin
                result[FIELD_W*i +: FIELD_W] = top;
            end else begin
                result[FIELD_W*i +: FIELD_W] = 8'h00;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_field.sv
// One two-digit BCD field: next value for an increment or decrement plus the
// carry/borrow that ripples into the next more significant field.
module bcd_field
    import time_pkg::*;
#(
    parameter logic [7:0] MAX = 8'h59
) (
    input  logic [7:0] value,
    input  logic       inc,
    input  logic       dec,
    output logic [7:0] next_value,
    output logic       carry,
    output logic       borrow
);

    // Next-value arithmetic for one BCD field.
    always_comb begin
        next_value = value;
        carry      = 1'b0;
        borrow     = 1'b0;
        if (inc) begin
            if (value == MAX) begin
                next_value = 8'h00;
                carry      = 1'b1;
            end else if (value[3:0] == 4'h9) begin
                next_value = {value[7:4] + 4'h1, 4'h0};
            end else begin
                next_value = {value[7:4], value[3:0] + 4'h1};
            end
        end else if (dec) begin
            if (value == 8'h00) begin
                next_value = MAX;
                borrow     = 1'b1;
            end else if (value[3:0] == 4'h0) begin
                next_value = {value[7:4] - 4'h1, 4'h9};
            end else begin
                next_value = {value[7:4], value[3:0] - 4'h1};
            end
        end else begin
            next_value = value;
        end
    end

endmodule

// File: rtl/bcd_time_counter.sv
// Multi-field BCD up/down time counter with validated load, roll-over pulse
// and a change-qualified alarm pulse.
module bcd_time_counter
    import time_pkg::*;
#(
    parameter int         FIELDS  = 2,
    parameter logic [7:0] TOP_MAX = 8'h59,
    localparam int        W       = 8 * FIELDS
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         run,
    input  logic         tick,
    input  logic         dir,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         alarm_en,
    input  logic [W-1:0] alarm_time,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         alarm_hit,
    output logic         load_err
);

    localparam logic [FIELD_W*MAX_FIELDS-1:0] ALL_MAX_WIDE = bcd_all_max(FIELDS, TOP_MAX);
    localparam logic [W-1:0] ALL_MAX = ALL_MAX_WIDE[W-1:0];

    logic [W-1:0]      count_r;
    logic [W-1:0]      count_prev_r;
    logic              wrap_r;
    logic              alarm_hit_r;
    logic              load_err_r;
    logic [W-1:0]      step_value_s;
    logic [FIELDS-1:0] inc_s;
    logic [FIELDS-1:0] dec_s;
    logic [FIELDS-1:0] carry_s;
    logic [FIELDS-1:0] borrow_s;
    logic              step_s;
    logic              load_ok_s;

    assign step_s   = run & tick;
    assign inc_s[0] = step_s & ~dir;
    assign dec_s[0] = step_s & dir;

    for (genvar i = 0; i < FIELDS; i++) begin : g_field
        if (i > 0) begin : g_chain
            assign inc_s[i] = carry_s[i-1];
            assign dec_s[i] = borrow_s[i-1];
        end
        bcd_field #(
            .MAX ((i == FIELDS - 1) ? TOP_MAX : SEC_MAX)
        ) u_field (
            .value      (count_r[8*i +: 8]),
            .inc        (inc_s[i]),
            .dec        (dec_s[i]),
            .next_value (step_value_s[8*i +: 8]),
            .carry      (carry_s[i]),
            .borrow     (borrow_s[i])
        );
    end

    // Load validation: every field must be BCD and within its own maximum.
    always_comb begin
        load_ok_s = 1'b1;
        for (int i = 0; i < FIELDS; i++) begin
            if (!bcd_field_valid(load_value[8*i +: 8], (i == FIELDS - 1) ? TOP_MAX : SEC_MAX)) begin
                load_ok_s = 1'b0;
            end else begin
                load_ok_s = load_ok_s;
            end
        end
    end

    // Count register, one-cycle pulses and alarm change-detect history.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r      <= {W{1'b0}};
            count_prev_r <= {W{1'b0}};
            wrap_r       <= 1'b0;
            alarm_hit_r  <= 1'b0;
            load_err_r   <= 1'b0;
        end else begin
            wrap_r     <= 1'b0;
            load_err_r <= 1'b0;
            if (load) begin
                if (load_ok_s) begin
                    count_r <= load_value;
                end else begin
                    load_err_r <= 1'b1;
                end
            end else if (step_s) begin
                if (carry_s[FIELDS-1]) begin
                    count_r <= {W{1'b0}};
                    wrap_r  <= 1'b1;
                end else if (borrow_s[FIELDS-1]) begin
                    count_r <= ALL_MAX;
                    wrap_r  <= 1'b1;
                end else begin
                    count_r <= step_value_s;
                end
            end else begin
                count_r <= count_r;
            end
            // Only a fresh change into the alarm value fires, so holding or enabling late does not.
            count_prev_r <= count_r;
            alarm_hit_r  <= alarm_en && (count_r == alarm_time) && (count_r != count_prev_r);
        end
    end

    assign count     = count_r;
    assign wrap      = wrap_r;
    assign alarm_hit = alarm_hit_r;
    assign load_err  = load_err_r;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed self-checking bench: an MM:SS instance and an HH:MM:SS instance.
module tb_bcd_time_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // MM:SS instance
    logic        a_reset = 1'b1, a_run = 1'b0, a_tick = 1'b0, a_dir = 1'b0, a_load = 1'b0;
    logic        a_alarm_en = 1'b0;
    logic [15:0] a_load_value = 16'h0000, a_alarm_time = 16'h0000, a_count;
    logic        a_wrap, a_alarm_hit, a_load_err;

    // HH:MM:SS instance
    logic        b_reset = 1'b1, b_run = 1'b0, b_tick = 1'b0, b_dir = 1'b0, b_load = 1'b0;
    logic        b_alarm_en = 1'b0;
    logic [23:0] b_load_value = 24'h000000, b_alarm_time = 24'h000000, b_count;
    logic        b_wrap, b_alarm_hit, b_load_err;

    bcd_time_counter #(.FIELDS(2), .TOP_MAX(8'h59)) dut_a (
        .clk(clk), .reset(a_reset), .run(a_run), .tick(a_tick), .dir(a_dir),
        .load(a_load), .load_value(a_load_value), .alarm_en(a_alarm_en),
        .alarm_time(a_alarm_time), .count(a_count), .wrap(a_wrap),
        .alarm_hit(a_alarm_hit), .load_err(a_load_err)
    );

    bcd_time_counter #(.FIELDS(3), .TOP_MAX(8'h23)) dut_b (
        .clk(clk), .reset(b_reset), .run(b_run), .tick(b_tick), .dir(b_dir),
        .load(b_load), .load_value(b_load_value), .alarm_en(b_alarm_en),
        .alarm_time(b_alarm_time), .count(b_count), .wrap(b_wrap),
        .alarm_hit(b_alarm_hit), .load_err(b_load_err)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic a_pulses(input string tag, input logic w, input logic h, input logic e);
        check_val({tag, "_wrap"}, {31'd0, a_wrap}, {31'd0, w});
        check_val({tag, "_hit"},  {31'd0, a_alarm_hit}, {31'd0, h});
        check_val({tag, "_err"},  {31'd0, a_load_err}, {31'd0, e});
    endtask

    task automatic a_do_load(input logic [15:0] v);
        a_load = 1'b1; a_load_value = v;
        cyc();
        a_load = 1'b0;
    endtask

    task automatic b_do_load(input logic [23:0] v);
        b_load = 1'b1; b_load_value = v;
        cyc();
        b_load = 1'b0;
    endtask

    initial begin
        cyc(); cyc();
        a_reset = 1'b0; b_reset = 1'b0;
        check_val("a_rst_count", {16'd0, a_count}, 32'h0000);
        a_pulses("a_rst", 1'b0, 1'b0, 1'b0);
        check_val("b_rst_count", {8'd0, b_count}, 32'h000000);

        // Up roll-over
        a_do_load(16'h5958);
        check_val("a_load5958", {16'd0, a_count}, 32'h5958);
        a_run = 1'b1; a_tick = 1'b1; a_dir = 1'b0;
        cyc();
        check_val("a_up_5959", {16'd0, a_count}, 32'h5959);
        check_val("a_up_nowrap", {31'd0, a_wrap}, 32'd0);
        cyc();
        check_val("a_up_wrap_cnt", {16'd0, a_count}, 32'h0000);
        check_val("a_up_wrap", {31'd0, a_wrap}, 32'd1);
        a_tick = 1'b0;
        cyc();
        check_val("a_wrap_once", {31'd0, a_wrap}, 32'd0);

        // Down steps and down roll-over
        a_do_load(16'h0100);
        a_dir = 1'b1; a_tick = 1'b1;
        cyc();
        a_tick = 1'b0;
        check_val("a_dn_0059", {16'd0, a_count}, 32'h0059);
        a_do_load(16'h0000);
        a_tick = 1'b1;
        cyc();
        a_tick = 1'b0;
        check_val("a_dn_wrap_cnt", {16'd0, a_count}, 32'h5959);
        check_val("a_dn_wrap", {31'd0, a_wrap}, 32'd1);
        cyc();
        check_val("a_dn_wrap_once", {31'd0, a_wrap}, 32'd0);

        // Alarm on counting into the compare value
        a_alarm_time = 16'h0005; a_alarm_en = 1'b1; a_dir = 1'b0;
        a_do_load(16'h0003);
        a_tick = 1'b1;
        cyc();
        check_val("a_al_0004", {16'd0, a_count}, 32'h0004);
        cyc();
        check_val("a_al_0005", {16'd0, a_count}, 32'h0005);
        check_val("a_al_early", {31'd0, a_alarm_hit}, 32'd0);
        a_run = 1'b0;
        cyc();
        check_val("a_al_hit", {31'd0, a_alarm_hit}, 32'd1);
        check_val("a_al_hold", {16'd0, a_count}, 32'h0005);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check_val("a_al_norepeat", {31'd0, a_alarm_hit}, 32'd0);
            check_val("a_run0_hold", {16'd0, a_count}, 32'h0005);
        end
        a_alarm_en = 1'b0;
        cyc();
        a_alarm_en = 1'b1;
        cyc(); cyc();
        check_val("a_al_late_en", {31'd0, a_alarm_hit}, 32'd0);

        // Load beats a same-cycle tick; bad loads rejected
        a_run = 1'b1; a_tick = 1'b1;
        a_do_load(16'h1230);
        a_tick = 1'b0;
        check_val("a_ld_tick", {16'd0, a_count}, 32'h1230);
        a_do_load(16'h1A00);
        check_val("a_bad_cnt", {16'd0, a_count}, 32'h1230);
        check_val("a_bad_err", {31'd0, a_load_err}, 32'd1);
        cyc();
        check_val("a_err_once", {31'd0, a_load_err}, 32'd0);
        a_do_load(16'h0060);
        check_val("a_bad_sec", {31'd0, a_load_err}, 32'd1);
        a_do_load(16'h6000);
        check_val("a_bad_top", {31'd0, a_load_err}, 32'd1);
        check_val("a_bad_keep", {16'd0, a_count}, 32'h1230);

        // Load into the alarm value fires the alarm
        a_do_load(16'h0005);
        check_val("a_ldal_early", {31'd0, a_alarm_hit}, 32'd0);
        cyc();
        check_val("a_ldal_hit", {31'd0, a_alarm_hit}, 32'd1);

        // Reset mid-count
        a_alarm_time = 16'h0000;
        a_do_load(16'h4510);
        a_tick = 1'b1;
        cyc();
        check_val("a_pre_rst", {16'd0, a_count}, 32'h4511);
        a_reset = 1'b1; a_run = 1'b0;
        cyc();
        a_reset = 1'b0;
        check_val("a_mid_rst", {16'd0, a_count}, 32'h0000);
        a_pulses("a_mid_rst", 1'b0, 1'b0, 1'b0);
        cyc(); cyc();
        a_pulses("a_post_rst", 1'b0, 1'b0, 1'b0);
        check_val("a_run0_tick", {16'd0, a_count}, 32'h0000);

        // Three-field instance with 23-hour top
        b_do_load(24'h235959);
        check_val("b_load", {8'd0, b_count}, 32'h235959);
        b_run = 1'b1; b_tick = 1'b1;
        cyc();
        b_tick = 1'b0;
        check_val("b_up_wrap_cnt", {8'd0, b_count}, 32'h000000);
        check_val("b_up_wrap", {31'd0, b_wrap}, 32'd1);
        b_do_load(24'h240000);
        check_val("b_bad_err", {31'd0, b_load_err}, 32'd1);
        check_val("b_bad_cnt", {8'd0, b_count}, 32'h000000);
        check_val("b_bad_nowrap", {31'd0, b_wrap}, 32'd0);
        b_dir = 1'b1; b_tick = 1'b1;
        cyc();
        b_tick = 1'b0;
        check_val("b_dn_wrap_cnt", {8'd0, b_count}, 32'h235959);
        check_val("b_dn_wrap", {31'd0, b_wrap}, 32'd1);
        b_do_load(24'h100000);
        b_tick = 1'b1;
        cyc();
        b_tick = 1'b0;
        check_val("b_dn_borrow", {8'd0, b_count}, 32'h095959);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_time_counter.md
# bcd_time_counter

Parametrised BCD time-of-day/stopwatch counter replacing the fixed MM:SS counter. It holds FIELDS two-digit BCD fields, most significant field first, and counts up or down on a qualified tick. It supports validated parallel load and raises a one-cycle alarm pulse when the count reaches a programmed time. Its `count` bus feeds the anode/segment multiplexer and the LED/alarm logic directly.

## Interface
- FIELDS, 2, number of 2-digit BCD fields (2 = MM:SS, 3 = HH:MM:SS); W = 8*FIELDS
- TOP_MAX, 8'h59, BCD maximum of the most significant field (e.g. 8'h23 for hours); lower fields always max 8'h59
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; clears all state
- run  in  1  counting enable
- tick  in  1  one-cycle advance strobe (e.g. 1 Hz enable); ignored unless run=1
- dir  in  1  0 = count up, 1 = count down
- load  in  1  parallel-load strobe
- load_value  in  W  BCD value to load
- alarm_en  in  1  enables alarm_hit generation
- alarm_time  in  W  BCD alarm compare value
- count  out  W  current BCD time, reset 0
- wrap  out  1  one-cycle pulse on full roll-over (max->0 up, 0->max down), reset 0
- alarm_hit  out  1  one-cycle pulse when count becomes equal to alarm_time, reset 0
- load_err  out  1  one-cycle pulse when a load is rejected, reset 0

## Operation
- Priority per cycle: reset > load > (run & tick) > hold.
- Load: accepted only if every digit ≤ 9, every lower field ≤ 8'h59 and top field ≤ TOP_MAX. Accepted: count <= load_value. Rejected: count unchanged, load_err=1 for one cycle.
- Up step: field 0 (least significant) increments. Units 9 -> 0 with tens+1. A field at its max -> 8'h00 with carry into the next field. A carry out of the top field sets count=0 and wrap=1.
- Down step: field 0 decrements. Units 0 -> 9 with tens-1. A field at 8'h00 -> its max with borrow into the next field. A borrow out of the top field sets count to all-max (top=TOP_MAX, others 8'h59) and wrap=1.
- A tick with run=0 is discarded, not queued. A dir change takes effect on the next accepted tick.
- alarm_hit: registered edge detect. It pulses in the cycle after count changes to a value equal to alarm_time, with alarm_en=1 at that time. Holding equality gives no repeat pulse.
- A load that makes count equal to alarm_time also fires alarm_hit.
- Setting alarm_en while count already equals alarm_time fires no pulse.
- Non-BCD states are unreachable; count is only ever written with validated or arithmetic values.

## Timing
- Step latency: count updates on the clk edge that samples run&tick=1; the new value is visible the next cycle.
- wrap is asserted in the same cycle the wrapped count first appears.
- load_err is asserted in the cycle after the rejected load.
- alarm_hit is asserted one cycle after the matching count appears.
- Back-to-back ticks on consecutive cycles each advance once; no throughput limit.
- load and tick in the same cycle: load wins and the tick is lost.
- Reset mid-count: next cycle count=0, all pulses 0, alarm edge-detect history cleared. A count of 0 directly after reset does not fire alarm_hit even if alarm_time=0.

## Structure
- Package `time_pkg`:
  - `localparam BCD_W=4`, `FIELD_W=8`, `SEC_MAX=8'h59`
  - function `bcd_field_valid(value, max)`
  - function `bcd_all_max(fields, top)`
- Sub-module `bcd_field`:
  - One instance per field: parameter MAX; inputs inc, dec; output carry/borrow.
  - Chained ripple-enable from field 0 upward; top instance uses TOP_MAX.
- Top level holds load validation, alarm edge detect and output registers.

## Test plan
- FIELDS=2, TOP_MAX=8'h59: load 16'h5958, dir=0, two ticks -> count 16'h5959 then 16'h0000 with wrap=1 for exactly one cycle.
- FIELDS=3, TOP_MAX=8'h23: load 24'h235959, one tick -> 24'h000000 and wrap pulse. Load 24'h240000 -> load_err pulse, count unchanged.
- dir=1 from 16'h0100, one tick -> 16'h0059. From 16'h0000, one tick -> 16'h5959 with wrap=1.
- alarm_time=16'h0005, alarm_en=1, count up from 16'h0003 -> single alarm_hit one cycle after count=16'h0005. Stopping with run=0 at 16'h0005 gives no further pulses.
- Load 16'h1230 with tick asserted in the same cycle -> count 16'h1230. Load 16'h1A00 -> load_err, no change.
- Reset asserted while counting at 16'h4510 -> next cycle count=0, wrap/alarm_hit/load_err=0. run=0 with ticks -> count holds.
